// File: rtl/nibble_serial_subtractor.sv
// Serial 16-bit subtractor: a - b - bin, one nibble per clock, start/busy/done handshake.
// Visible results and flags are registered and change only on the completing edge.
module nibble_serial_subtractor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] diff,
  output logic        bout,
  output logic        zero,
  output logic        ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        borrow_q, borrow_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] part_q, part_d;
  logic [15:0] diff_q, diff_d;
  logic        bout_q, bout_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  logic [3:0]  a_nib [4];
  logic [3:0]  b_nib [4];
  logic [3:0]  cur_a;
  logic [3:0]  cur_b;
  logic [4:0]  nib_sub;
  logic [15:0] part_ins;

  // Nibble views of the latched operands and the partial result with the
  // current nibble merged in, so the final edge sees the complete difference.
  for (genvar gi = 0; gi < 4; gi++) begin : g_nib
    assign a_nib[gi] = a_q[4*gi +: 4];
    assign b_nib[gi] = b_q[4*gi +: 4];
    assign part_ins[4*gi +: 4] = (idx_q == 2'(gi)) ? nib_sub[3:0] : part_q[4*gi +: 4];
  end

  assign cur_a   = a_nib[idx_q];
  assign cur_b   = b_nib[idx_q];
  // Bit 4 of the 5-bit difference is the borrow out of this nibble.
  assign nib_sub = {1'b0, cur_a} - {1'b0, cur_b} - {4'b0000, borrow_q};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    part_d   = part_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CALC;
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          idx_d    = 2'd0;
        end
      end
      CALC: begin
        part_d   = part_ins;
        borrow_d = nib_sub[4];
        idx_d    = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = IDLE;
          diff_d  = part_ins;
          bout_d  = nib_sub[4];
          zero_d  = (part_ins == 16'h0000);
          ovf_d   = (a_q[15] ^ b_q[15]) & (part_ins[15] ^ a_q[15]);
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      borrow_q <= 1'b0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      part_q   <= 16'h0000;
      diff_q   <= 16'h0000;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      part_q   <= part_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: directed cases, reset abort, then random
// operations checked against plain integer arithmetic on every done.
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        bin = 1'b0;
  logic        busy, done, bout, zero, ovf;
  logic [15:0] diff;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  nibble_serial_subtractor dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .zero (zero),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one operation from the current negedge and checks it on done.
  // With mid set, the operands are scrambled and start pulsed during CALC.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tbin, input bit mid);
    int          n;
    int          busy_n;
    int          ra, rb, rbin;
    logic [15:0] ediff;
    logic        ebout, ezero, eovf;
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_n = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && n < 20) begin
      if (mid && n == 2) begin
        a = ~ta; b = 16'($urandom); bin = ~tbin; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (busy === 1'b1) busy_n++;
    end
    start = 1'b0;
    ra = int'(ta); rb = int'(tb_); rbin = int'(tbin);
    ediff = 16'((ra - rb - rbin) & 32'hFFFF);
    ebout = (ra < rb + rbin);
    ezero = (ediff == 16'h0000);
    eovf  = (ta[15] != tb_[15]) && (ediff[15] != ta[15]);
    check({tag, " latency"}, n, 5);
    check({tag, " busy_cycles"}, busy_n, 4);
    check({tag, " diff"}, diff, ediff);
    check({tag, " bout"}, bout, ebout);
    check({tag, " zero"}, zero, ezero);
    check({tag, " ovf"}, ovf, eovf);
    $display("op %s a=%h b=%h bin=%0d -> diff=%h bout=%0d zero=%0d ovf=%0d",
             tag, ta, tb_, tbin, diff, bout, zero, ovf);
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst diff", diff, 0);
    check("rst flags", {bout, zero, ovf}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("zero", 16'h0000, 16'h0000, 1'b0, 0);
    run_op("wrap", 16'h0000, 16'h0001, 1'b0, 0);
    run_op("bin1", 16'h5678, 16'h1234, 1'b1, 0);
    run_op("ovf_pos", 16'h8000, 16'h0001, 1'b0, 0);
    run_op("ovf_neg", 16'h7FFF, 16'hFFFF, 1'b0, 0);

    @(negedge clk);
    d0 = done_cnt;
    run_op("ignored", 16'h1234, 16'h0234, 1'b0, 1);
    run_op("b2b", 16'hAAAA, 16'h5555, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - d0, 2);

    a = 16'hFFFF; b = 16'h0001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort diff", diff, 0);
    check("abort flags", {bout, zero, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    check("abort no_done", done_cnt - d0, 0);
    $display("op abort a=ffff b=0001 bin=0 -> reset mid-calc");
    run_op("after_abort", 16'h1000, 16'h0FFF, 1'b0, 0);

    for (int i = 0; i < 1000; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
